// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between four byte requesters, the arbiter and a UART transmitter.
//
// Signals:
//   req      [3:0]  per-requester send request (bit i = requester i)
//   data_in  [31:0] requester i's byte on data_in[8i+7:8i]
//   ack      [3:0]  one-cycle capture pulse back to the granted requester
//   busy_tx         UART transmitter busy flag
//   transmit        one-cycle start pulse to the UART
//   data_tx  [7:0]  byte presented to the UART
//   grant_id [1:0]  current or most recent granted requester
//   active          high from grant until the transfer completes
//   err             one-cycle pulse when busy_tx never rose after a transmit
//
// Modports: slave = arbiter side, master = requesters/UART side.
interface uart_tx_arbiter_if;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  ack;
    logic        busy_tx;
    logic        transmit;
    logic [7:0]  data_tx;
    logic [1:0]  grant_id;
    logic        active;
    logic        err;

    modport slave (
        input  req, data_in, busy_tx,
        output ack, transmit, data_tx, grant_id, active, err
    );

    modport master (
        output req, data_in, busy_tx,
        input  ack, transmit, data_tx, grant_id, active, err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between four byte requesters.
//
// A grant latches the winner's byte, pulses its ack, then issues a one-cycle transmit and
// follows busy_tx through its rise and fall. If busy_tx does not rise within BUSY_TIMEOUT
// cycles the transfer is abandoned with an err pulse.
//
// Ports:
//   clk   system clock, rising edge
//   nRst  asynchronous active-low reset
//   bus   uart_tx_arbiter_if.slave (req, data_in, busy_tx in; ack, transmit, data_tx,
//         grant_id, active, err out)
//
// Build option: define UART_ARB_TAG_EN to precede each data byte with the tag byte
// {6'b101000, grant_id}; both bytes belong to one grant and share one ack.
module uart_tx_arbiter #(
    parameter int unsigned BUSY_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              nRst,
    uart_tx_arbiter_if.slave  bus
);

    localparam int unsigned TimerW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitHi,
        StWaitLo
    } state_e;

    state_e            state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [1:0]        last_grant_q, last_grant_d;
    logic [1:0]        grant_id_q, grant_id_d;
    logic [7:0]        data_tx_q, data_tx_d;
    logic [3:0]        ack_q, ack_d;
    logic              active_q, active_d;
    logic              err_q, err_d;

`ifdef UART_ARB_TAG_EN
    logic [7:0]        byte_q, byte_d;      // data byte parked while the tag goes out
    logic              tag_phase_q, tag_phase_d;
`endif

    logic       win_valid;
    logic [1:0] win_id;
    logic [1:0] cand;
    logic [7:0] win_byte;

    // Search starts one past the last completed grant; 2-bit arithmetic wraps 3 -> 0.
    always_comb begin
        win_valid = 1'b0;
        win_id    = last_grant_q;
        cand      = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = last_grant_q + 2'(k);
            if (!win_valid && bus.req[cand]) begin
                win_valid = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign win_byte = bus.data_in[{win_id, 3'b000} +: 8];

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        data_tx_d    = data_tx_q;
        ack_d        = '0;
        active_d     = active_q;
        err_d        = 1'b0;
`ifdef UART_ARB_TAG_EN
        byte_d       = byte_q;
        tag_phase_d  = tag_phase_q;
`endif

        unique case (state_q)
            StIdle: begin
                // An externally busy UART blocks arbitration entirely.
                if (win_valid && !bus.busy_tx) begin
                    ack_d      = 4'b0001 << win_id;
                    grant_id_d = win_id;
                    active_d   = 1'b1;
                    state_d    = StIssue;
`ifdef UART_ARB_TAG_EN
                    byte_d      = win_byte;
                    data_tx_d   = {6'b101000, win_id};
                    tag_phase_d = 1'b1;
`else
                    data_tx_d   = win_byte;
`endif
                end
            end

            StIssue: begin
                timer_d = '0;
                state_d = StWaitHi;
            end

            StWaitHi: begin
                if (bus.busy_tx) begin
                    state_d = StWaitLo;
                end else if (timer_q == TimerW'(BUSY_TIMEOUT - 1)) begin
                    // UART never acknowledged: drop the whole grant, history untouched.
                    err_d    = 1'b1;
                    active_d = 1'b0;
                    timer_d  = '0;
                    state_d  = StIdle;
`ifdef UART_ARB_TAG_EN
                    tag_phase_d = 1'b0;
`endif
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end

            StWaitLo: begin
                if (!bus.busy_tx) begin
`ifdef UART_ARB_TAG_EN
                    if (tag_phase_q) begin
                        tag_phase_d = 1'b0;
                        data_tx_d   = byte_q;
                        state_d     = StIssue;
                    end else begin
                        last_grant_d = grant_id_q;
                        active_d     = 1'b0;
                        state_d      = StIdle;
                    end
`else
                    last_grant_d = grant_id_q;
                    active_d     = 1'b0;
                    state_d      = StIdle;
`endif
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            last_grant_q <= 2'd3;  // requester 0 wins first after reset
            grant_id_q   <= '0;
            data_tx_q    <= '0;
            ack_q        <= '0;
            active_q     <= 1'b0;
            err_q        <= 1'b0;
`ifdef UART_ARB_TAG_EN
            byte_q       <= '0;
            tag_phase_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            data_tx_q    <= data_tx_d;
            ack_q        <= ack_d;
            active_q     <= active_d;
            err_q        <= err_d;
`ifdef UART_ARB_TAG_EN
            byte_q       <= byte_d;
            tag_phase_q  <= tag_phase_d;
`endif
        end
    end

    assign bus.transmit = (state_q == StIssue);
    assign bus.ack      = ack_q;
    assign bus.data_tx  = data_tx_q;
    assign bus.grant_id = grant_id_q;
    assign bus.active   = active_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized requesters
// and UART behaviour, compared every cycle against a transfer-level reference model.
module tb_uart_tx_arbiter;

    localparam int unsigned BT = 8;
`ifdef UART_ARB_TAG_EN
    localparam int NB  = 2;
    localparam bit TAG = 1'b1;
`else
    localparam int NB  = 1;
    localparam bit TAG = 1'b0;
`endif

    logic        clk  = 1'b0;
    logic        nRst = 1'b1;
    logic [3:0]  req_v = '0;
    logic [31:0] din_v = '0;
    logic        uart_busy = 1'b0;
    logic        ext_busy  = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_arbiter_if bus ();

    assign bus.req     = req_v;
    assign bus.data_in = din_v;
    assign bus.busy_tx = uart_busy | ext_busy;

    uart_tx_arbiter #(
        .BUSY_TIMEOUT(BT)
    ) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model (transfer level) ----------------
    int         m_last;
    int         m_w;
    int         m_waited;
    bit         m_granted, m_issue, m_rose;
    logic [1:0] m_gid;
    logic [7:0] m_q[$];          // bytes of the current grant still to be sent
    logic [3:0] e_ack;
    logic       e_tx, e_err, e_active;
    logic [1:0] e_gid;
    logic [7:0] e_data;

    function automatic int rr_pick(input int last, input logic [3:0] r);
        for (int k = 1; k <= 4; k++)
            if (r[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge nRst);
            if (!nRst) begin
                m_last = 3; m_granted = 0; m_issue = 0; m_rose = 0; m_waited = 0;
                m_q.delete();
                e_ack = '0; e_tx = 0; e_err = 0; e_active = 0; e_gid = '0; e_data = '0;
            end else begin
                e_ack = '0; e_tx = 0; e_err = 0;
                if (!m_granted) begin
                    m_w = rr_pick(m_last, bus.req);
                    if (m_w >= 0 && !bus.busy_tx) begin
                        m_granted = 1;
                        m_gid = 2'(m_w);
                        m_q.delete();
                        if (TAG) m_q.push_back({6'b101000, m_gid});
                        m_q.push_back(bus.data_in[8*m_w +: 8]);
                        e_ack = 4'b0001 << m_w;
                        e_gid = m_gid; e_active = 1; e_data = m_q[0]; e_tx = 1;
                        m_issue = 1;
                    end
                end else if (m_issue) begin
                    m_issue = 0; m_rose = 0; m_waited = 0;
                end else if (!m_rose) begin
                    if (bus.busy_tx) m_rose = 1;
                    else if (m_waited == int'(BT) - 1) begin
                        e_err = 1; e_active = 0; m_granted = 0;
                    end else m_waited++;
                end else if (!bus.busy_tx) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) begin
                        m_last = int'(m_gid); m_granted = 0; e_active = 0;
                    end else begin
                        e_data = m_q[0]; e_tx = 1; m_issue = 1; m_rose = 0;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("ack",      32'(bus.ack),      32'(e_ack));
                chk("transmit", 32'(bus.transmit), 32'(e_tx));
                chk("err",      32'(bus.err),      32'(e_err));
                chk("active",   32'(bus.active),   32'(e_active));
                chk("grant_id", 32'(bus.grant_id), 32'(e_gid));
                chk("data_tx",  32'(bus.data_tx),  32'(e_data));
            end
        end
    end

    // ---------------- event monitor ----------------
    int         ack_log[$];
    logic [7:0] tx_log[$];
    int         tx_cyc[$];
    int         err_cyc[$];
    int         busy_fall = 0, act_fall = 0;
    logic       busy_prev = 1'b0, act_prev = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (nRst) begin
                for (int i = 0; i < 4; i++) if (bus.ack[i]) ack_log.push_back(i);
                if (bus.transmit) begin
                    tx_log.push_back(bus.data_tx);
                    tx_cyc.push_back(cyc);
                end
                if (bus.err) err_cyc.push_back(cyc);
                if (busy_prev && !bus.busy_tx) busy_fall = cyc;
                if (act_prev && !bus.active) act_fall = cyc;
            end
            busy_prev = bus.busy_tx;
            act_prev  = bus.active;
        end
    end

    // ---------------- UART model ----------------
    int uart_mode = 0;   // 0: fixed hold, 1: never raises busy, 2: random
    int uart_hold = 10;
    int u_h;

    initial begin
        forever begin
            @(negedge clk);
            if (nRst && bus.transmit === 1'b1) begin
                if (uart_mode == 2) u_h = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
                else if (uart_mode == 1) u_h = 0;
                else u_h = uart_hold;
                if (u_h > 0) begin
                    @(posedge clk); #1 uart_busy = 1'b1;
                    repeat (u_h) @(posedge clk);
                    #1 uart_busy = 1'b0;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_logs();
        ack_log.delete(); tx_log.delete(); tx_cyc.delete(); err_cyc.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ack"},      32'(bus.ack),      32'h0);
        chk({tag, "_transmit"}, 32'(bus.transmit), 32'h0);
        chk({tag, "_data_tx"},  32'(bus.data_tx),  32'h0);
        chk({tag, "_grant_id"}, 32'(bus.grant_id), 32'h0);
        chk({tag, "_active"},   32'(bus.active),   32'h0);
        chk({tag, "_err"},      32'(bus.err),      32'h0);
    endtask

    task automatic apply_reset();
        tick(); nRst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst");
        tick(); nRst = 1'b1;
    endtask

    task automatic wait_ack(input int budget, output logic [3:0] got);
        got = '0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.ack != 0) begin got = bus.ack; break; end
        end
        chk("ack_arrival", 32'(got != 0), 32'h1);
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!bus.active && !bus.busy_tx) begin ok = 1; break; end
        end
        chk("idle_arrival", 32'(ok), 32'h1);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not end, got running, expected finished");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    logic [3:0] got;
    bit         seen;
    int         exp_id[5]   = '{0, 1, 2, 3, 0};
    logic [7:0] exp_byte[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

    initial begin
        #2 nRst = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);
        check_reset_outputs("por");
        tick(); nRst = 1'b1;

        // Single request from requester 0.
        clear_logs();
        din_v = 32'h0000_0055; req_v = 4'b0001;
        wait_ack(20, got);
        chk("t1_ack", 32'(got), 32'h1);
        tick(); req_v = '0;
        wait_idle(60); repeat (3) tick();
        chk("t1_ack_count", 32'(ack_log.size()), 32'd1);
        chk("t1_tx_count",  32'(tx_log.size()),  32'(NB));
        chk("t1_data",      32'(tx_log[NB-1]),   32'h55);
        chk("t1_active_falls_after_busy", 32'(act_fall - busy_fall), 32'd1);

        // All four requesting: strict rotation.
        apply_reset();
        clear_logs();
        din_v = 32'h4433_2211; req_v = 4'b1111;
        for (int k = 0; k < 5; k++) wait_ack(80, got);
        tick(); req_v = '0;
        wait_idle(80); repeat (3) tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t2_grant%0d", k), 32'(ack_log[k]), 32'(exp_id[k]));
            chk($sformatf("t2_byte%0d", k),  32'(tx_log[k*NB + NB - 1]), 32'(exp_byte[k]));
        end

        // UART never answers: timeout, then the next request is served.
        clear_logs();
        uart_mode = 1; req_v = 4'b0001;
        wait_ack(20, got);
        tick(); req_v = '0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.err) begin seen = 1; break; end
        end
        chk("t3_err_seen", 32'(seen), 32'h1);
        repeat (2) tick();
        chk("t3_err_count", 32'(err_cyc.size()), 32'd1);
        chk("t3_err_delay", 32'(err_cyc[0] - tx_cyc[0]), 32'(BT + 1));
        chk("t3_active_low", 32'(bus.active), 32'h0);
        uart_mode = 0; req_v = 4'b0010;
        wait_ack(20, got);
        chk("t3_next_served", 32'(got), 32'h2);
        tick(); req_v = '0;
        wait_idle(60);

        // External busy blocks arbitration.
        tick(); ext_busy = 1'b1; req_v = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t4_no_ack_while_busy", 32'(bus.ack), 32'h0);
        end
        tick(); ext_busy = 1'b0;
        wait_ack(20, got);
        chk("t4_ack", 32'(got), 32'h4);
        tick(); req_v = '0;
        wait_idle(60);

        // Reset during WAIT_LO abandons the byte; requester 0 gets first priority again.
        req_v = 4'b0010;
        wait_ack(20, got);
        chk("t5_ack", 32'(got), 32'h2);
        tick(); req_v = '0;
        clear_logs();
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.busy_tx) begin seen = 1; break; end
        end
        chk("t5_busy_seen", 32'(seen), 32'h1);
        repeat (2) tick();
        nRst = 1'b0;
        @(negedge clk);
        check_reset_outputs("t5_mid");
        tick(); nRst = 1'b1;
        wait_idle(60); repeat (3) tick();
        chk("t5_no_ack_after", 32'(ack_log.size()), 32'd0);
        chk("t5_no_err_after", 32'(err_cyc.size()), 32'd0);
        din_v = 32'h4433_2211; req_v = 4'b1111;
        wait_ack(20, got);
        chk("t5_req0_first", 32'(got), 32'h1);
        tick(); req_v = '0;
        wait_idle(60);

`ifdef UART_ARB_TAG_EN
        // Tag byte precedes the data byte within one grant.
        repeat (2) tick();
        clear_logs();
        din_v = 32'h0000_C300; req_v = 4'b0010;
        wait_ack(20, got);
        tick(); req_v = '0;
        wait_idle(80); repeat (3) tick();
        chk("t6_ack_count", 32'(ack_log.size()), 32'd1);
        chk("t6_tx_count",  32'(tx_log.size()),  32'd2);
        chk("t6_tag",       32'(tx_log[0]),      32'hA1);
        chk("t6_data",      32'(tx_log[1]),      32'hC3);
`endif

        // Randomized traffic: requesters come and go, UART hold varies, occasional timeouts.
        uart_mode = 2;
        for (int n = 0; n < 3000; n++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                if (bus.ack[i]) req_v[i] = 1'b0;
                else if (req_v[i] && $urandom_range(0, 31) == 0) req_v[i] = 1'b0;
                else if (!req_v[i] && $urandom_range(0, 3) == 0) begin
                    req_v[i] = 1'b1;
                    din_v[8*i +: 8] = 8'($urandom);
                end
            end
            if (ext_busy) begin
                if ($urandom_range(0, 7) == 0) ext_busy = 1'b0;
            end else if ($urandom_range(0, 63) == 0) ext_busy = 1'b1;
        end
        req_v = '0; ext_busy = 1'b0; uart_mode = 0;
        wait_idle(100);
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter BUSY_TIMEOUT, default 8, the number of cycles allowed for busy_tx to rise after a transmit pulse.
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port nRst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  input  4  per-requester send request; bit i = requester i.
REQ-005 SHALL have port data_in  input  32  byte for requester i on data_in[8i+7:8i].
REQ-006 SHALL have port ack  output  4  one-cycle pulse; bit i means requester i's byte was captured.
REQ-007 SHALL have port busy_tx  input  1  UART transmitter busy flag.
REQ-008 SHALL have port transmit  output  1  one-cycle start pulse to the UART.
REQ-009 SHALL have port data_tx  output  8  byte presented to the UART.
REQ-010 SHALL have port grant_id  output  2  index of the current or most recent granted requester.
REQ-011 SHALL have port active  output  1  high from grant until the transfer completes.
REQ-012 SHALL have port err  output  1  one-cycle pulse on a busy_tx timeout.

Function
REQ-013 SHALL implement the FSM states IDLE, ISSUE, WAIT_HI and WAIT_LO.
REQ-014 In IDLE, when req!=0 and busy_tx==0, SHALL grant one requester using round-robin order starting at last_grant+1 (mod 4).
REQ-015 On a grant, in the same clock edge, SHALL latch the winner's byte, pulse ack[winner], set grant_id, set active=1 and enter ISSUE.
REQ-016 In IDLE with busy_tx==1 (UART in use externally), SHALL NOT grant.
REQ-017 In ISSUE, SHALL assert transmit for exactly one cycle with data_tx stable, then enter WAIT_HI with the timer cleared.
REQ-018 In WAIT_HI, when busy_tx==1, SHALL enter WAIT_LO.
REQ-019 In WAIT_HI, when busy_tx==0, SHALL increment the timer; when the timer reaches BUSY_TIMEOUT-1, SHALL pulse err, clear active and return to IDLE.
REQ-020 In WAIT_LO, when busy_tx==0, SHALL complete the byte.
REQ-021 On transfer completion, SHALL set last_grant to grant_id, clear active and return to IDLE.
REQ-022 Minimum gap between the end of one transfer and the next grant SHALL be one IDLE cycle.
REQ-023 Requesters SHALL hold req and data_in until ack; dropping req before ack SHALL withdraw the request with no side effect.
REQ-024 ack SHALL NOT assert for more than one bit per cycle and SHALL NOT assert outside a grant.
REQ-025 data_tx and grant_id SHALL hold their last values between transfers.
REQ-026 req changes during ISSUE, WAIT_HI or WAIT_LO SHALL NOT affect the transfer in progress.
REQ-027 Timer width SHALL be sized to hold BUSY_TIMEOUT; arbitration pointer arithmetic SHALL wrap 3 -> 0.

Reset
REQ-028 On nRst low, SHALL asynchronously set state=IDLE, ack=0, transmit=0, data_tx=0, grant_id=0, active=0, err=0, timer=0 and last_grant=3, so requester 0 has first priority.
REQ-029 Reset mid-transfer SHALL abandon the byte with no ack or err afterwards; the already-started UART frame is not recalled.

Configuration
REQ-030 With UART_ARB_TAG_EN defined, each grant SHALL send two bytes: first the tag {6'b101000, grant_id}, then the data byte, each with its own ISSUE/WAIT_HI/WAIT_LO pass.
REQ-031 With UART_ARB_TAG_EN defined, active SHALL stay high across both bytes, and a timeout on either byte SHALL abort the whole grant.
REQ-032 Without UART_ARB_TAG_EN, SHALL send only the data byte, with no tag logic present.

Verification
REQ-033 Stimulus: reset, then req=4'b0001 with byte0=8'h55, and a UART model that raises busy 1 cycle after transmit and holds it 10 cycles. Response: ack=0001 once, transmit one cycle with data_tx=55, active falls after busy falls.
REQ-034 Stimulus: req=4'b1111 held with bytes 11/22/33/44. Response: grant order 0,1,2,3,0 with data_tx 11,22,33,44,11.
REQ-035 Stimulus: busy_tx never rises after transmit, BUSY_TIMEOUT=8. Response: err pulses 8 cycles after WAIT_HI entry, FSM returns to IDLE and the next request is served.
REQ-036 Stimulus: busy_tx=1 externally while req=4'b0100. Response: no ack until busy_tx falls, then ack=0100.
REQ-037 Stimulus: nRst pulsed during WAIT_LO. Response: all outputs return to reset values, no ack or err follows, and requester 0 wins next.
REQ-038 Stimulus: UART_ARB_TAG_EN defined, req=4'b0010 with byte1=8'hC3. Response: data_tx sequence A1 then C3, two transmit pulses, one ack.
